// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// KEY_MAP is indexed by {row, col}; entry 0 is the top-left key.
package keypad_pkg;

  localparam int KPD_N = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    WAIT_RELEASE
  } state_t;

  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Resets to all-ones so idle pulled-up lines do not look active.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner: column drive, press/release debounce and hex encoding.
// Emits a one-cycle data_available strobe per accepted press.
module keypad_scan_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       data_available,
  output logic       key_down
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       rows_s;
  logic             row_hit;
  logic [1:0]       hit_row;
  logic             same_row;
  logic [1:0]       col_idx;
  logic [1:0]       lat_row;
  logic [1:0]       lat_col;
  logic [CNT_W-1:0] deb_cnt;
  logic             col_adv;
  logic             enter_emit;
  logic             release_done;

  sync_2ff #(
    .WIDTH(KPD_N)
  ) u_row_sync (
    .clk(clk),
    .rst(rst),
    .d  (row_in),
    .q  (rows_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // Scanning downward lets the lowest-indexed low row win.
  always_comb begin
    row_hit = ~&rows_s;
    hit_row = '0;
    for (int i = KPD_N - 1; i >= 0; i--) begin
      if (!rows_s[i]) hit_row = 2'(i);
    end
  end

  assign same_row = row_hit && (hit_row == lat_row);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SCAN;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      SCAN: begin
        if (tick && row_hit) state_n = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (tick) begin
          if (!same_row)               state_n = SCAN;
          else if (deb_cnt == DEB_LAST) state_n = EMIT;
        end
      end
      EMIT: begin
        state_n = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (tick && !row_hit && (deb_cnt == DEB_LAST)) state_n = SCAN;
      end
      default: begin
        state_n = SCAN;
      end
    endcase
  end

  always_comb begin
    data_available = (state == EMIT);
  end

  assign enter_emit   = (state == DEBOUNCE) && (state_n == EMIT);
  assign release_done = (state == WAIT_RELEASE) && (state_n == SCAN);
  assign col_adv      = ((state == SCAN) && tick && !row_hit) ||
                        ((state == DEBOUNCE) && tick && !same_row) ||
                        release_done;

  // key_code and key_down load on entry to EMIT so both are valid with the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_idx  <= '0;
      lat_row  <= '0;
      lat_col  <= '0;
      deb_cnt  <= '0;
      key_code <= '0;
      key_down <= 1'b0;
    end else begin
      if (col_adv) col_idx <= col_idx + 1'b1;
      case (state)
        SCAN: begin
          if (tick && row_hit) begin
            lat_row <= hit_row;
            lat_col <= col_idx;
            deb_cnt <= '0;
          end
        end
        DEBOUNCE: begin
          if (tick && same_row && (deb_cnt != DEB_LAST)) deb_cnt <= deb_cnt + 1'b1;
        end
        EMIT: begin
          deb_cnt <= '0;
        end
        WAIT_RELEASE: begin
          if (tick) begin
            if (row_hit)                  deb_cnt <= '0;
            else if (deb_cnt != DEB_LAST) deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: begin
          deb_cnt <= '0;
        end
      endcase
      if (enter_emit) begin
        key_code <= KEY_MAP[{lat_row, lat_col}];
        key_down <= 1'b1;
      end
      if (release_done) key_down <= 1'b0;
    end
  end

  assign col_out = ~(4'b0001 << col_idx);

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Scoreboard bench for keypad_scan_encoder with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A keypad model pulls a row low only while its pressed key's column is driven.
module tb_keypad_scan_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        data_available;
  logic        key_down;
  logic [15:0] keys = '0;

  int         compared   = 0;
  int         mismatched = 0;
  int         strobes    = 0;
  logic [3:0] exp_q[$];
  logic       prev_da = 1'b0;

  always #5 clk = ~clk;

  keypad_scan_encoder #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .row_in        (row_in),
    .col_out       (col_out),
    .key_code      (key_code),
    .data_available(data_available),
    .key_down      (key_down)
  );

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] k, input bit expect_strobe, input logic [3:0] code);
    keys = k;
    if (expect_strobe) exp_q.push_back(code);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge just after col_out switched to target.
  task automatic wait_col(input logic [3:0] target);
    logic [3:0] last;
    bit         found;
    last  = col_out;
    found = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      if (col_out == target && last != target) found = 1'b1;
      last = col_out;
    end
    if (!found) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_col: col_out=%b never reached %b", col_out, target);
    end
  endtask

  task automatic press_key(input logic [15:0] k, input logic [3:0] target, input logic [3:0] code);
    wait_col(target);
    applyStimulus(k, 1'b1, code);
    cycles(20);
    applyStimulus('0, 1'b0, 4'h0);
    cycles(24);
    checkOutput("key_down_released", {7'b0, key_down}, 8'h00);
  endtask

  always @(negedge clk) begin
    if (!rst && data_available) begin
      strobes++;
      checkOutput("da_not_consecutive", {7'b0, prev_da}, 8'h00);
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_strobe: key_code=%h, expected no strobe at %0t", key_code, $time);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        checkOutput("key_code", {4'b0, key_code}, {4'b0, e});
        checkOutput("key_down_at_strobe", {7'b0, key_down}, 8'h01);
      end
    end
    prev_da <= data_available;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] rot [4];
    int         s;
    rot[0] = 4'b1101;
    rot[1] = 4'b1011;
    rot[2] = 4'b0111;
    rot[3] = 4'b1110;

    // Reset values and free-running column rotation.
    rst = 1'b1;
    applyStimulus('0, 1'b0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_col_out", {4'b0, col_out}, 8'h0E);
    checkOutput("rst_key_code", {4'b0, key_code}, 8'h00);
    checkOutput("rst_data_available", {7'b0, data_available}, 8'h00);
    checkOutput("rst_key_down", {7'b0, key_down}, 8'h00);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycles(4);
      checkOutput("rotate_col_out", {4'b0, col_out}, {4'b0, rot[k]});
    end

    // Press '5' held for 200 cycles: one strobe at P+16.
    wait_col(4'b1101);
    s = strobes;
    applyStimulus(16'h0020, 1'b1, 4'h5);
    cycles(15);
    checkOutput("key_down_before_accept", {7'b0, key_down}, 8'h00);
    cycles(2);
    checkOutput("strobe_count_after_accept", 8'(strobes - s), 8'h01);
    checkOutput("key_down_held", {7'b0, key_down}, 8'h01);
    cycles(183);
    checkOutput("single_strobe_long_hold", 8'(strobes - s), 8'h01);
    applyStimulus('0, 1'b0, 4'h0);
    cycles(8);
    checkOutput("key_down_during_release", {7'b0, key_down}, 8'h01);
    cycles(12);
    checkOutput("key_down_after_release", {7'b0, key_down}, 8'h00);
    checkOutput("key_code_kept_after_release", {4'b0, key_code}, 8'h05);

    // Press bounce: only detect tick plus one matching tick.
    wait_col(4'b1101);
    s = strobes;
    applyStimulus(16'h0020, 1'b0, 4'h0);
    cycles(8);
    applyStimulus('0, 1'b0, 4'h0);
    cycles(4);
    checkOutput("bounce_col_advances", {4'b0, col_out}, 8'h0B);
    checkOutput("bounce_key_down", {7'b0, key_down}, 8'h00);
    cycles(4);
    checkOutput("bounce_scan_resumes", {4'b0, col_out}, 8'h07);
    checkOutput("bounce_no_strobe", 8'(strobes - s), 8'h00);

    // Encoding of row 3 and lowest-row priority.
    press_key(16'h1000, 4'b1110, 4'hE);
    press_key(16'h4000, 4'b1011, 4'hF);
    press_key(16'h8000, 4'b0111, 4'hD);
    press_key(16'h2000, 4'b1101, 4'h0);
    press_key(16'h0404, 4'b1011, 4'h3);

    // Release bounce: re-press after two high ticks restarts the release count.
    wait_col(4'b1110);
    s = strobes;
    applyStimulus(16'h0001, 1'b1, 4'h1);
    cycles(17);
    applyStimulus('0, 1'b0, 4'h0);
    cycles(7);
    applyStimulus(16'h0001, 1'b0, 4'h0);
    cycles(4);
    applyStimulus('0, 1'b0, 4'h0);
    cycles(11);
    checkOutput("release_bounce_key_down_held", {7'b0, key_down}, 8'h01);
    cycles(1);
    checkOutput("release_bounce_key_down_clear", {7'b0, key_down}, 8'h00);
    checkOutput("release_bounce_one_strobe", 8'(strobes - s), 8'h01);

    // Reset after two matching ticks discards the pending press.
    wait_col(4'b1101);
    applyStimulus(16'h0020, 1'b0, 4'h0);
    cycles(12);
    rst = 1'b1;
    #1;
    checkOutput("midrst_col_out", {4'b0, col_out}, 8'h0E);
    checkOutput("midrst_key_code", {4'b0, key_code}, 8'h00);
    checkOutput("midrst_data_available", {7'b0, data_available}, 8'h00);
    checkOutput("midrst_key_down", {7'b0, key_down}, 8'h00);
    cycles(2);
    s = strobes;
    rst = 1'b0;
    applyStimulus(16'h0020, 1'b1, 4'h5);
    cycles(19);
    checkOutput("midrst_no_early_strobe", 8'(strobes - s), 8'h00);
    cycles(2);
    checkOutput("midrst_fresh_strobe", 8'(strobes - s), 8'h01);
    applyStimulus('0, 1'b0, 4'h0);
    cycles(24);
    checkOutput("midrst_key_down_released", {7'b0, key_down}, 8'h00);

    checkOutput("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/keypad_scan_encoder.md
Name: keypad_scan_encoder

Overview:
- Drives and scans a 4x4 matrix keypad, debounces each press and encodes it to a 4-bit hex key code.
- Emits a single-cycle data_available strobe per accepted press, with key_code stable from that cycle onward.
- Producer end of the keypad-capture path. The strobe feeds the downstream enable-register that latches key_code.
- Target is the Tang Nano 9k at 27 MHz.

Parameters:
- SCAN_DIV, 27000: clk cycles per scan tick (1 ms at 27 MHz). Minimum 2.
- DEBOUNCE_SCANS, 10: consecutive matching ticks required to accept a press and to accept a release. Minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- row_in  in  4  keypad rows, active-low, pulled up, asynchronous to clk
- col_out  out  4  keypad column drive, active-low, exactly one bit low at all times
- key_code  out  4  encoded code of the last accepted key
- data_available  out  1  one-cycle strobe, key_code valid in the same cycle
- key_down  out  1  high from strobe until the release is debounced

Behaviour:
- Reset values: col_out=4'b1110 (column 0), key_code=0, data_available=0, key_down=0, state SCAN, all counters 0, synchronizer flops 1.
- row_in passes through a 2-flop synchronizer (rows_s). All row decisions use rows_s.
- Tick divider:
  - Counts 0..SCAN_DIV-1, then wraps.
  - tick is high for one cycle when the count equals SCAN_DIV-1.
  - Runs freely in every state.
- Row select: a row is "hit" when its bit of rows_s is 0. With several rows low, the lowest row index wins.
- FSM:
  - SCAN:
    - On tick with no row hit: column index advances 0->1->2->3->0 and col_out follows.
    - On tick with a row hit: latch (row, current col), debounce counter=0, go DEBOUNCE. The column stays put.
  - DEBOUNCE: column held. On tick:
    - Same row still hit and counter==DEBOUNCE_SCANS-1: go EMIT.
    - Same row still hit otherwise: counter++.
    - No hit or a different row: go SCAN and advance the column.
  - EMIT (exactly 1 cycle):
    - key_code <= KEY_MAP[row*4+col].
    - data_available=1.
    - key_down=1.
    - Then go WAIT_RELEASE with counter=0.
  - WAIT_RELEASE: column held. On tick:
    - All rows high and counter==DEBOUNCE_SCANS-1: key_down=0, go SCAN, advance the column.
    - All rows high otherwise: counter++.
    - Any row low: counter=0.
- Latency:
  - A press is accepted after 1 detecting tick plus DEBOUNCE_SCANS matching ticks.
  - data_available is asserted in the clk cycle after the final matching tick.
- A press held indefinitely produces exactly one strobe. Auto-repeat is not supported.
- key_code holds its value until the next EMIT and is unaffected by release.
- data_available is never high in two consecutive cycles.
- Reset asserted mid-operation: immediate return to reset values. A pending press is discarded with no strobe.
- Key map, index row*4+col:
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: * 0 # D
  - '*' encodes as 0xE and '#' as 0xF.

Decomposition:
- Package keypad_pkg:
  - State enum {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE}.
  - KPD_N=4.
  - KEY_MAP, a 16-entry by 4-bit constant, in the order above.
- Sub-module sync_2ff, parameterised WIDTH, reset value all-ones. Instantiated once for row_in.
- Divider, FSM and encoder stay in keypad_scan_encoder.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3):
- Reset: hold rst 3 cycles, rows idle 4'hF -> col_out=1110, key_code=0, data_available=0, key_down=0. col_out then rotates 1101, 1011, 0111, 1110, one step every 4 cycles.
- Press '5' (row1 low while col1 driven), held for 200 cycles -> exactly one data_available pulse, key_code=4'h5 in the same cycle, key_down=1. After release plus 3 high ticks: key_down=0 and scanning resumes.
- Bounce: row1 low at col1 for 2 ticks, then high -> no strobe, back to SCAN, col_out advances to 1011.
- Encoding: row3 at col0 -> 4'hE; row3 at col2 -> 4'hF; row3 at col3 -> 4'hD; row3 at col1 -> 4'h0. Also rows 0 and 2 low together at col2 -> 4'h3 (lowest row wins).
- Release bounce: in WAIT_RELEASE toggle row low after 2 high ticks -> counter restarts, no second strobe, key_down stays 1 until 3 consecutive high ticks.
- Reset mid-DEBOUNCE (after 2 matching ticks) -> all outputs return to reset values. No strobe after rst deasserts while the row stays low, until a fresh 1+3 tick sequence completes.
